// File: rtl/ddu_pkg.sv
// Shared definitions for the CPU debug unit: view-select encodings, address width
// and the hex-to-seven-segment font used by the display scanner.
package ddu_pkg;

  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    VIEW_DATA = 2'b00,
    VIEW_PC   = 2'b01,
    VIEW_IR   = 2'b10,
    VIEW_ADDR = 2'b11
  } view_e;

  // Active-high {g,f,e,d,c,b,a} patterns, entry 15 (F) first down to entry 0.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Returns the active-low {dp,g..a} drive for one hex digit.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib, input logic dp_on);
    return {~dp_on, ~SEG_FONT[nib]};
  endfunction

endpackage

// File: rtl/ddu_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge pulse for one raw
// board switch or button.
module ddu_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let sync_q[1] see this edge's raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise   <= 1'b0;
      // Any return to the accepted level restarts the count, so bounce is ignored.
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync_q[1];
        rise  <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_debug_unit.sv
// Board-side debug unit for the multi-cycle CPU: run/step control, inspection
// address, 8-digit display scanner. Optional breakpoint halt via DDU_BREAKPOINT_EN.
module cpu_debug_unit
  import ddu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned SCAN_DIV        = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DDU_BREAKPOINT_EN
  input  logic        bp_en,
  input  logic [31:0] bp_pc,
`endif
  input  logic        sw_run,
  input  logic        sw_mem,
  input  logic [1:0]  sw_view,
  input  logic        btn_step,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [31:0] mem_data,
  input  logic [31:0] reg_data,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  output logic        run,
  output logic        cont,
  output logic [31:0] ddu_addr,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic              run_mode, run_mode_q, mem_sel;
  logic [1:0]        view;
  logic              step_rise, inc_rise, dec_rise;
  logic [3:0]        sw_rise_unused;
  logic [ADDR_W-1:0] addr;
  logic              halt;

  ddu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .raw(sw_run), .level(run_mode), .rise(sw_rise_unused[0]));
  ddu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mem (
    .clk(clk), .rst_n(rst_n), .raw(sw_mem), .level(mem_sel), .rise(sw_rise_unused[1]));
  ddu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_view0 (
    .clk(clk), .rst_n(rst_n), .raw(sw_view[0]), .level(view[0]), .rise(sw_rise_unused[2]));
  ddu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_view1 (
    .clk(clk), .rst_n(rst_n), .raw(sw_view[1]), .level(view[1]), .rise(sw_rise_unused[3]));

  logic step_level_unused, inc_level_unused, dec_level_unused;

  ddu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .raw(btn_step), .level(step_level_unused), .rise(step_rise));
  ddu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .raw(btn_inc), .level(inc_level_unused), .rise(inc_rise));
  ddu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk(clk), .rst_n(rst_n), .raw(btn_dec), .level(dec_level_unused), .rise(dec_rise));

`ifdef DDU_BREAKPOINT_EN
  logic bp_match, bp_match_q;
  assign bp_match = bp_en && (pc == bp_pc);

  // Halt arms on arrival at bp_pc, so a step off the breakpoint is not re-caught
  // while the CPU is still finishing that instruction with pc unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt       <= 1'b0;
      bp_match_q <= 1'b0;
    end else begin
      bp_match_q <= bp_match;
      if (!run_mode)                   halt <= 1'b0;
      else if (halt && step_rise)      halt <= 1'b0;
      else if (bp_match && !bp_match_q) halt <= 1'b1;
    end
  end

  assign run = run_mode & ~halt;
`else
  assign halt = 1'b0;
  assign run  = run_mode;
`endif

  // run_mode_q masks a step edge arriving in the same clock that run mode drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_mode_q <= 1'b0;
      cont       <= 1'b0;
      addr       <= '0;
    end else begin
      run_mode_q <= run_mode;
      cont       <= step_rise && (halt || (!run_mode && !run_mode_q));
      if (inc_rise && !dec_rise)      addr <= addr + 1'b1;
      else if (dec_rise && !inc_rise) addr <= addr - 1'b1;
    end
  end

  assign ddu_addr = {{(32 - ADDR_W){1'b0}}, addr};
  assign led      = {addr[7] | halt, addr[6:0], pc[9:2]};

  logic [31:0]      disp_word;
  logic [3:0]       nibble;
  logic [2:0]       digit;
  logic [DIV_W-1:0] div;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    disp_word = reg_data;
    case (view_e'(view))
      VIEW_DATA: disp_word = mem_sel ? mem_data : reg_data;
      VIEW_PC:   disp_word = pc;
      VIEW_IR:   disp_word = ir;
      VIEW_ADDR: disp_word = ddu_addr;
      default:   disp_word = reg_data;
    endcase
  end

  assign nibble = disp_word[{digit, 2'b00} +: 4];

  // an and seg are registered together so they always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      digit <= '0;
      an    <= 8'hFE;
      seg   <= 8'hFF;
    end else begin
      if (div == DIV_MAX) begin
        div   <= '0;
        digit <= digit + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      an  <= ~(8'b1 << digit);
      seg <= hex_to_seg(nibble, (digit == 3'd7) && run);
    end
  end

endmodule
